// File: rtl/bht_predictor.sv
// Branch history table: 2-bit saturating counters with a 1-cycle registered prediction.
// Define BHT_PREDICTOR_GSHARE_EN to XOR a global history into the index (gshare).
module bht_predictor #(
    parameter int unsigned BHT_ENTRIES = 32,
    parameter int unsigned BHT_HIST    = 3,
    parameter int unsigned VLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_bp_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    input  logic            update_valid_i,
    input  logic [VLEN-1:0] update_pc_i,
    input  logic            update_taken_i
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       cnt [BHT_ENTRIES];
    logic [IDX_W-1:0] lkp_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_old;
    logic [1:0]       upd_new;
    logic [1:0]       lkp_cnt;
    logic             pred_valid;
    logic             pred_taken;
    logic             unused_bits;

`ifdef BHT_PREDICTOR_GSHARE_EN
    logic [BHT_HIST-1:0] hist;

    // Both indices use the history held at the start of the cycle.
    assign lkp_idx = lookup_pc_i[IDX_W:1] ^ IDX_W'(hist);
    assign upd_idx = update_pc_i[IDX_W:1] ^ IDX_W'(hist);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist <= '0;
        end else if (flush_bp_i) begin
            hist <= '0;
        end else if (update_valid_i) begin
            hist <= BHT_HIST'({hist, update_taken_i});
        end
    end

    assign unused_bits = ^{lookup_pc_i[VLEN-1:IDX_W+1], lookup_pc_i[0],
                           update_pc_i[VLEN-1:IDX_W+1], update_pc_i[0]};
`else
    localparam logic [0:0] HistLsb = 1'(BHT_HIST);

    assign lkp_idx = lookup_pc_i[IDX_W:1];
    assign upd_idx = update_pc_i[IDX_W:1];

    assign unused_bits = ^{lookup_pc_i[VLEN-1:IDX_W+1], lookup_pc_i[0],
                           update_pc_i[VLEN-1:IDX_W+1], update_pc_i[0], HistLsb};
`endif

    assign upd_old = cnt[upd_idx];

    always_comb begin
        upd_new = upd_old;
        if (update_taken_i) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    // Same-cycle update to the looked-up entry is forwarded into the prediction.
    always_comb begin
        lkp_cnt = cnt[lkp_idx];
        if (update_valid_i && (upd_idx == lkp_idx)) lkp_cnt = upd_new;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) cnt[i] <= 2'b01;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else if (flush_bp_i) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) cnt[i] <= 2'b01;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            if (update_valid_i) cnt[upd_idx] <= upd_new;
            pred_valid <= lookup_valid_i;
            pred_taken <= lookup_valid_i & lkp_cnt[1];
        end
    end

    assign pred_valid_o = pred_valid;
    assign pred_taken_o = pred_taken;

endmodule

// File: tb/tb_bht_predictor.sv
// Randomised and directed bench for bht_predictor against a per-cycle behavioural model.
// Honours BHT_PREDICTOR_GSHARE_EN in the same way as the design.
module tb_bht_predictor;

    localparam int unsigned ENTRIES = 32;
    localparam int unsigned HIST    = 3;
    localparam int unsigned VLEN    = 32;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_bp_i = 1'b0;
    logic            lookup_valid_i = 1'b0;
    logic [VLEN-1:0] lookup_pc_i = '0;
    logic            pred_valid_o;
    logic            pred_taken_o;
    logic            update_valid_i = 1'b0;
    logic [VLEN-1:0] update_pc_i = '0;
    logic            update_taken_i = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int   m_cnt [ENTRIES];
    int   m_hist;
    logic exp_valid;
    logic exp_taken;

    bht_predictor #(
        .BHT_ENTRIES (ENTRIES),
        .BHT_HIST    (HIST),
        .VLEN        (VLEN)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_bp_i     (flush_bp_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .update_valid_i (update_valid_i),
        .update_pc_i    (update_pc_i),
        .update_taken_i (update_taken_i)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < int'(ENTRIES); i++) m_cnt[i] = 1;
        m_hist    = 0;
        exp_valid = 1'b0;
        exp_taken = 1'b0;
    endfunction

    function automatic int m_idx(input logic [VLEN-1:0] pc);
        int b;
        b = int'((pc >> 1) % ENTRIES);
`ifdef BHT_PREDICTOR_GSHARE_EN
        b = b ^ m_hist;
`endif
        return b;
    endfunction

    // One clock: drive inputs, advance the model, return 1 ns after the edge.
    task automatic drive(input logic lv, input logic [VLEN-1:0] lpc, input logic uv,
                         input logic [VLEN-1:0] upc, input logic ut, input logic fl);
        int li;
        int ui;
        lookup_valid_i = lv;
        lookup_pc_i    = lpc;
        update_valid_i = uv;
        update_pc_i    = upc;
        update_taken_i = ut;
        flush_bp_i     = fl;
        li = m_idx(lpc);
        ui = m_idx(upc);
        if (fl) begin
            for (int i = 0; i < int'(ENTRIES); i++) m_cnt[i] = 1;
            m_hist    = 0;
            exp_valid = 1'b0;
            exp_taken = 1'b0;
        end else begin
            if (uv) begin
                if (ut) m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
                else    m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
                m_hist = ((m_hist << 1) | int'(ut)) & ((1 << HIST) - 1);
            end
            exp_valid = lv;
            exp_taken = lv && (m_cnt[li] >= 2);
        end
        @(posedge clk);
        #1;
        lookup_valid_i = 1'b0;
        update_valid_i = 1'b0;
        flush_bp_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        m_reset();
        #3;
        n_cmp++;
        if (pred_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", pred_valid_o);
        end
        n_cmp++;
        if (pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_taken: got %b want 0", pred_taken_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        drive(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL first_lookup: got v=%b t=%b want v=1 t=0", pred_valid_o, pred_taken_o);
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid: got %b want 0", pred_valid_o);
        end
    endtask

`ifndef BHT_PREDICTOR_GSHARE_EN
    task automatic test_saturate();
        do_reset();
        repeat (2) drive(1'b0, '0, 1'b1, 32'h8000_0004, 1'b1, 1'b0);
        drive(1'b1, 32'h8000_0004, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_taken: got v=%b t=%b want v=1 t=1", pred_valid_o, pred_taken_o);
        end
        repeat (4) drive(1'b0, '0, 1'b1, 32'h8000_0004, 1'b0, 1'b0);
        drive(1'b1, 32'h8000_0004, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_nt: got %b want 0", pred_taken_o);
        end
        // From 00 one taken update only reaches 01.
        drive(1'b0, '0, 1'b1, 32'h8000_0004, 1'b1, 1'b0);
        drive(1'b1, 32'h8000_0004, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_floor: got %b want 0", pred_taken_o);
        end
        // Aliasing: upper address bits ignored.
        drive(1'b0, '0, 1'b1, 32'h0000_0004, 1'b1, 1'b0);
        drive(1'b1, 32'h1234_5684, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alias: got %b want 1", pred_taken_o);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0);
        n_cmp++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass: got v=%b t=%b want v=1 t=1", pred_valid_o, pred_taken_o);
        end
    endtask
`else
    task automatic test_gshare();
        do_reset();
        drive(1'b0, '0, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 32'h0, 1'b0, 1'b0);
        // History 110: 0xC maps to entry 0, which the first update left at 10.
        drive(1'b1, 32'hC, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_taken_o !== 1'b1 || pred_taken_o !== exp_taken) begin
            n_fail++;
            $display("FAIL gshare_lookup: got %b want 1 (model %b)", pred_taken_o, exp_taken);
        end
        // Entry 3 was decremented to 00 by the third update; 0x0 with history 110 hits 6.
        drive(1'b1, 32'h0, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gshare_other: got %b want 0", pred_taken_o);
        end
        repeat (2) drive(1'b1, 32'hC, 1'b1, 32'hC, 1'b1, 1'b0);
        drive(1'b1, 32'hC, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_taken_o !== exp_taken) begin
            n_fail++;
            $display("FAIL gshare_model: got %b want %b", pred_taken_o, exp_taken);
        end
    endtask
`endif

    task automatic test_flush();
        do_reset();
        repeat (3) drive(1'b0, '0, 1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1);
        n_cmp++;
        if (pred_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid: got %b want 0", pred_valid_o);
        end
        drive(1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: got v=%b t=%b want v=1 t=0", pred_valid_o, pred_taken_o);
        end
        // 01 after flush: one taken update must flip to taken.
        drive(1'b0, '0, 1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_taken_o !== exp_taken) begin
            n_fail++;
            $display("FAIL flush_weak: got %b want %b", pred_taken_o, exp_taken);
        end
    endtask

    task automatic test_back_to_back();
        logic [VLEN-1:0] pc;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pc = VLEN'($urandom_range(0, 63));
            drive(1'b1, pc, 1'b1, VLEN'($urandom_range(0, 63)), 1'($urandom), 1'b0);
            n_cmp++;
            if (pred_valid_o !== 1'b1 || pred_taken_o !== exp_taken) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got v=%b t=%b want v=1 t=%b", i, pred_valid_o,
                         pred_taken_o, exp_taken);
            end
        end
    endtask

    task automatic test_random();
        logic            lv;
        logic            uv;
        logic            fl;
        logic            same;
        logic [VLEN-1:0] lpc;
        logic [VLEN-1:0] upc;
        for (int i = 0; i < 400; i++) begin
            lv   = 1'($urandom_range(0, 3) != 0);
            uv   = 1'($urandom_range(0, 3) != 0);
            fl   = 1'($urandom_range(0, 49) == 0);
            same = 1'($urandom_range(0, 3) == 0);
            lpc  = {VLEN'($urandom_range(0, 7)) << 20} | VLEN'($urandom_range(0, 31) << 1)
                   | VLEN'($urandom_range(0, 1));
            upc  = same ? lpc : ({VLEN'($urandom_range(0, 7)) << 20}
                   | VLEN'($urandom_range(0, 31) << 1));
            drive(lv, lpc, uv, upc, 1'($urandom), fl);
            n_cmp++;
            if (pred_valid_o !== exp_valid || (exp_valid && pred_taken_o !== exp_taken)) begin
                n_fail++;
                $display("FAIL rnd[%0d]: got v=%b t=%b want v=%b t=%b", i, pred_valid_o,
                         pred_taken_o, exp_valid, exp_taken);
            end
        end
    endtask

    task automatic test_reset_midop();
        repeat (3) drive(1'b0, '0, 1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== exp_taken) begin
            n_fail++;
            $display("FAIL midop_pre: got v=%b t=%b want v=1 t=%b", pred_valid_o, pred_taken_o,
                     exp_taken);
        end
        // Half-cycle reset pulse with an update in flight.
        rst_ni         = 1'b0;
        update_valid_i = 1'b1;
        update_pc_i    = 32'h40;
        update_taken_i = 1'b1;
        m_reset();
        #1;
        n_cmp++;
        if (pred_valid_o !== 1'b0 || pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_async: got v=%b t=%b want v=0 t=0", pred_valid_o, pred_taken_o);
        end
        #4;
        rst_ni         = 1'b1;
        update_valid_i = 1'b0;
        drive(1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_post: got v=%b t=%b want v=1 t=0", pred_valid_o, pred_taken_o);
        end
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
        n_cmp++;
        if (pred_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_weak: got %b want 1", pred_taken_o);
        end
    endtask

    initial begin
        m_reset();
        test_reset();
`ifndef BHT_PREDICTOR_GSHARE_EN
        test_saturate();
        test_bypass();
`else
        test_gshare();
`endif
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
